// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and full/empty flags.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
// Optional build macro FIFO_STATUS_EN adds the count, overflow and underflow outputs.
module sync_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cs,
  input  logic                          wr_en,
  input  logic                          rd_en,
  input  logic [DATA_WIDTH-1:0]         data_in,
  output logic [DATA_WIDTH-1:0]         data_out,
  output logic                          empty,
  output logic                          full
`ifdef FIFO_STATUS_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          underflow
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  wr_fire;
  logic                  rd_fire;

  // Flags come straight from the pre-edge pointers, so a write into a full FIFO
  // is blocked even when a read frees a slot on the same edge.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                   (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign wr_fire = cs && wr_en && !full;
  assign rd_fire = cs && rd_en && !empty;

  // Storage array: write-only port, left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst && wr_fire) begin
      mem[wr_ptr_reg[AW-1:0]] <= data_in;
    end
  end

  // Registered read port: data_out changes only on an accepted read or reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_out <= '0;
    end else if (rd_fire) begin
      data_out <= mem[rd_ptr_reg[AW-1:0]];
    end
  end

  // Pointer advance; the wrap bit toggles naturally on the extra MSB.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
    end
  end

`ifdef FIFO_STATUS_EN
  // Occupancy is the modular pointer difference, 0..FIFO_DEPTH.
  assign count = wr_ptr_reg - rd_ptr_reg;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (cs && wr_en && full) begin
        overflow <= 1'b1;
      end
      if (cs && rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed test of sync_fifo against a queue-based reference model.
// Honours FIFO_STATUS_EN when the design is built with it.
module tb_sync_fifo;

  localparam int DEPTH = 8;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          empty;
  logic          full;
`ifdef FIFO_STATUS_EN
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;
`endif

  sync_fifo #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cs       (cs),
    .wr_en    (wr_en),
    .rd_en    (rd_en),
    .data_in  (data_in),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
`ifdef FIFO_STATUS_EN
    ,
    .count    (count),
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: a queue of stored words plus the last word read out.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  bit            model_valid = 1'b0;

  always @(posedge clk) begin
    int sz;
    sz = q.size();
    if (!rst) begin
      q.delete();
      m_dout = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      model_valid = 1'b1;
    end else if (cs) begin
      if (wr_en && sz == DEPTH) m_ovf = 1'b1;
      if (rd_en && sz == 0)     m_unf = 1'b1;
      if (rd_en && sz > 0)      m_dout = q.pop_front();
      if (wr_en && sz < DEPTH)  q.push_back(data_in);
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (model_valid) begin
      check("model_data_out", data_out, m_dout);
      check("model_empty", {31'd0, empty}, {31'd0, q.size() == 0});
      check("model_full", {31'd0, full}, {31'd0, q.size() == DEPTH});
`ifdef FIFO_STATUS_EN
      check("model_count", {{(DW-CW){1'b0}}, count}, q.size());
      check("model_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("model_underflow", {31'd0, underflow}, {31'd0, m_unf});
`endif
    end
  end

  // Apply one cycle of stimulus at a falling edge; return at the next falling edge.
  task automatic cyc(input logic r, input logic c, input logic w, input logic rd, input logic [DW-1:0] d);
    rst = r; cs = c; wr_en = w; rd_en = rd; data_in = d;
    @(negedge clk);
    $display("cyc t=%0t rst=%0b cs=%0b wr=%0b rd=%0b din=0x%0h -> dout=0x%0h empty=%0b full=%0b",
             $time, r, c, w, rd, d, data_out, empty, full);
  endtask

  task automatic wr(input logic [DW-1:0] d); cyc(1, 1, 1, 0, d); endtask
  task automatic rd();                       cyc(1, 1, 0, 1, '0); endtask

  initial begin
    @(negedge clk);
    // Reset state
    cyc(0, 0, 0, 0, '0);
    check("reset_dout", data_out, 32'd0);
    check("reset_empty", {31'd0, empty}, 32'd1);
    check("reset_full", {31'd0, full}, 32'd0);

    // Three writes, three reads
    wr(32'd1); wr(32'd10); wr(32'd100);
    check("t1_not_full", {31'd0, full}, 32'd0);
    rd(); check("t1_rd0", data_out, 32'd1);
    rd(); check("t1_rd1", data_out, 32'd10);
    rd(); check("t1_rd2", data_out, 32'd100);
    check("t1_empty", {31'd0, empty}, 32'd1);

    // Write/read pairs of powers of two; pointers wrap past index 7
    for (int i = 0; i < 8; i++) begin
      wr(32'd1 << i);
      rd();
      check("t2_rd", data_out, 32'd1 << i);
      check("t2_empty", {31'd0, empty}, 32'd1);
    end

    // Fill, overflow attempt, drain
    for (int i = 0; i < 8; i++) wr(32'd1 << i);
    check("t3_full", {31'd0, full}, 32'd1);
    wr(32'hDEAD);
    check("t3_full_hold", {31'd0, full}, 32'd1);
`ifdef FIFO_STATUS_EN
    check("t3_overflow", {31'd0, overflow}, 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      rd();
      check("t3_rd", data_out, 32'd1 << i);
    end
    check("t3_empty", {31'd0, empty}, 32'd1);

    // Simultaneous write+read while full: read wins, write blocked
    for (int i = 0; i < 8; i++) wr(32'h100 + i);
    cyc(1, 1, 1, 1, 32'h99);
    check("t3b_rd", data_out, 32'h100);
    check("t3b_not_full", {31'd0, full}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      rd();
      check("t3b_drain", data_out, 32'h100 + i);
    end
    check("t3b_empty", {31'd0, empty}, 32'd1);

    // Read while empty after reset
    cyc(0, 0, 0, 0, '0);
    rd();
    check("t4_dout", data_out, 32'd0);
    check("t4_empty", {31'd0, empty}, 32'd1);
`ifdef FIFO_STATUS_EN
    check("t4_underflow", {31'd0, underflow}, 32'd1);
`endif

    // cs=0 blocks writes; simultaneous write+read while empty only writes
    cyc(1, 0, 1, 0, 32'h55);
    check("t5_cs0_empty", {31'd0, empty}, 32'd1);
    cyc(1, 1, 1, 1, 32'h77);
    check("t5_rw_empty_dout", data_out, 32'd0);
    check("t5_rw_empty_notempty", {31'd0, empty}, 32'd0);
`ifdef FIFO_STATUS_EN
    check("t5_count", {{(DW-CW){1'b0}}, count}, 32'd1);
`endif
    cyc(1, 0, 0, 1, '0);
    check("t5_cs0_rd_hold", data_out, 32'd0);
    rd();
    check("t5_rd", data_out, 32'h77);

    // Mid-operation reset discards contents
    wr(32'd3); wr(32'd4); wr(32'd5);
    rd();
    check("t6_pre_rd", data_out, 32'd3);
    cyc(0, 1, 1, 1, 32'hAA);
    check("t6_empty", {31'd0, empty}, 32'd1);
    check("t6_full", {31'd0, full}, 32'd0);
    check("t6_dout", data_out, 32'd0);
    wr(32'd7);
    rd();
    check("t6_rd7", data_out, 32'd7);
    check("t6_empty_end", {31'd0, empty}, 32'd1);

    cyc(1, 0, 0, 0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
